// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_e : REQ (request outstanding or about to issue) / FULL (buffer holds an instruction)
//   RESET_PC_DEF  : default PC after reset
//   NOP_INSTR_DEF : default bubble encoding driven when the buffer is empty
//   PC_INC        : sequential PC step
package if_pkg;

  typedef enum logic {
    REQ  = 1'b0,
    FULL = 1'b1
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INC        = 32'd4;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register.
// Owns the PC, keeps at most one imem request in flight, and holds the returned
// instruction until the pipeline consumes it (pc_write_i=1).
//
// Ports:
//   clk_i, rst_n_i          clock / async active-low reset
//   pc_write_i              1 = consume the buffered instruction, 0 = stall
//   branch_taken_i          single-cycle redirect from ID
//   branch_target_i[31:0]   redirect address
//   imem_req_o, imem_addr_o request toward instruction memory (addr == PC)
//   imem_ack_i, imem_rdata_i response strobe / data (ack may coincide with req)
//   pc_o                    current PC
//   pc4_o, instr_o          address+4 and encoding of the buffered instruction
//   fetch_valid_o           buffer holds a live instruction
//   misalign_o              (IF_MISALIGN_CHK_EN only) one-cycle pulse after a
//                           redirect whose target had [1:0] != 0
//
// Build option: define IF_MISALIGN_CHK_EN to add misalign_o and force redirect
// targets to word alignment.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        pc_write_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  output logic [31:0] instr_o,
`ifdef IF_MISALIGN_CHK_EN
  output logic        misalign_o,
`endif
  output logic        fetch_valid_o
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc;
  logic [31:0]  pending_pc;
  logic         discard;
  logic [31:0]  target;

`ifdef IF_MISALIGN_CHK_EN
  assign target = {branch_target_i[31:2], 2'b00};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) misalign_o <= 1'b0;
    else          misalign_o <= branch_taken_i && (branch_target_i[1:0] != 2'b00);
  end
`else
  assign target = branch_target_i;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= REQ;
    else          state <= state_nxt;
  end

  // Next state: only a clean (non-discarded, non-redirected) ack fills the buffer.
  always_comb begin
    state_nxt = state;
    case (state)
      REQ:  if (imem_ack_i && !branch_taken_i && !discard) state_nxt = FULL;
      FULL: if (branch_taken_i || pc_write_i)              state_nxt = REQ;
      default: state_nxt = REQ;
    endcase
  end

  // Outputs: address is the PC, which only moves on ack or outside REQ, so it
  // stays stable for the whole life of a request.
  always_comb begin
    imem_req_o  = (state == REQ);
    imem_addr_o = pc;
    pc_o        = pc;
  end

  // PC, redirect bookkeeping and output buffer
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc            <= RESET_PC;
      pending_pc    <= 32'h0;
      discard       <= 1'b0;
      pc4_o         <= 32'h0;
      instr_o       <= NOP_INSTR;
      fetch_valid_o <= 1'b0;
    end else begin
      case (state)
        REQ: begin
          if (imem_ack_i) begin
            if (branch_taken_i) begin
              // redirect wins over the returning data
              pc      <= target;
              discard <= 1'b0;
            end else if (discard) begin
              // stale response from before a redirect: drop it, jump now
              pc      <= pending_pc;
              discard <= 1'b0;
            end else begin
              instr_o       <= imem_rdata_i;
              pc4_o         <= pc + PC_INC;
              fetch_valid_o <= 1'b1;
              pc            <= pc + PC_INC;
            end
          end else if (branch_taken_i) begin
            // request in flight: keep the address steady, apply target on ack
            pending_pc <= target;
            discard    <= 1'b1;
          end
        end
        FULL: begin
          if (branch_taken_i) begin
            pc            <= target;
            fetch_valid_o <= 1'b0;
            instr_o       <= NOP_INSTR;
          end else if (pc_write_i) begin
            fetch_valid_o <= 1'b0;
            instr_o       <= NOP_INSTR;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
